// File: rtl/powlib_fifo_unpack_pkg.sv
// rtl/powlib_fifo_unpack_pkg.sv - shared helpers for the FIFO read-side unpacker
package powlib_fifo_unpack_pkg;

  // Bits needed to index 'value' items (ceil(log2(value))).
  function automatic int powlib_clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_fifo_unpack_if.sv
// rtl/powlib_fifo_unpack_if.sv - wide-entry input and narrow-beat output handshakes
interface powlib_fifo_unpack_if
  import powlib_fifo_unpack_pkg::*;
#(
  parameter int W = 8,
  parameter int R = 4
);
  localparam int WL = powlib_clogb2(R);

  logic [R*W-1:0] wrdata;
  logic [WL-1:0]  wrlen;
  logic           wrvld;
  logic           wrrdy;
  logic [W-1:0]   rddata;
  logic           rdlast;
  logic           rdvld;
  logic           rdrdy;

  modport master (
    output wrdata, wrlen, wrvld, rdrdy,
    input  wrrdy, rddata, rdlast, rdvld
  );

  modport slave (
    input  wrdata, wrlen, wrvld, rdrdy,
    output wrrdy, rddata, rdlast, rdvld
  );
endinterface

// File: rtl/powlib_fifo_unpack_sel.sv
// rtl/powlib_fifo_unpack_sel.sv - picks narrow beat idx_i out of a held wide entry
module powlib_fifo_unpack_sel
  import powlib_fifo_unpack_pkg::*;
#(
  parameter int W    = 8,
  parameter int R    = 4,
  parameter int EMSB = 0,
  parameter int WL   = powlib_clogb2(R)
) (
  input  logic [R*W-1:0] data_i,
  input  logic [WL-1:0]  idx_i,
  output logic [W-1:0]   beat_o
);
  logic [W-1:0] beats [R];

  // EMSB reverses beat order so beat 0 is the most significant slice.
  for (genvar i = 0; i < R; i++) begin : g_beat
    localparam int SLICE = (EMSB != 0) ? (R - 1 - i) : i;
    assign beats[i] = data_i[SLICE*W +: W];
  end

  assign beat_o = beats[idx_i];
endmodule

// File: rtl/powlib_fifo_unpack.sv
// rtl/powlib_fifo_unpack.sv - replays one popped wide FIFO entry as a stream of narrow beats
module powlib_fifo_unpack
  import powlib_fifo_unpack_pkg::*;
#(
  parameter int    W    = 8,
  parameter int    R    = 4,
  parameter int    EMSB = 0,
  parameter int    EDBG = 0,
  parameter string ID   = "UNPACK"
) (
  input  logic              clk,
  input  logic              rst,
  powlib_fifo_unpack_if.slave bus
);
  localparam int            WL   = powlib_clogb2(R);
  localparam logic [WL-1:0] LMAX = WL'(R - 1);

  if (EDBG != 0 && R < 2) begin : g_bad_r
    $error("%s: R must be at least 2", ID);
  end

  logic           busy_q, busy_d;
  logic [WL-1:0]  idx_q, idx_d;
  logic [WL-1:0]  len_q, len_d;
  logic [R*W-1:0] data_q, data_d;
  logic           wrinc, rdinc, last;

  assign last  = busy_q && (idx_q == len_q);
  assign rdinc = busy_q && bus.rdrdy;
  // Refill in the same cycle the last beat leaves, so entries run back to back.
  assign bus.wrrdy  = rst && (!busy_q || (rdinc && last));
  assign wrinc      = bus.wrvld && bus.wrrdy;
  assign bus.rdvld  = busy_q;
  assign bus.rdlast = last;

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    len_d  = len_q;
    data_d = data_q;
    if (rdinc) begin
      if (last) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (wrinc) begin
      busy_d = 1'b1;
      idx_d  = '0;
      data_d = bus.wrdata;
      len_d  = (bus.wrlen > LMAX) ? LMAX : bus.wrlen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      len_q  <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      data_q <= data_d;
    end
  end

  powlib_fifo_unpack_sel #(
    .W    (W),
    .R    (R),
    .EMSB (EMSB),
    .WL   (WL)
  ) u_sel (
    .data_i (data_q),
    .idx_i  (idx_q),
    .beat_o (bus.rddata)
  );
endmodule

// File: tb/tb_powlib_fifo_unpack.sv
// tb/tb_powlib_fifo_unpack.sv - scoreboard bench for powlib_fifo_unpack
module tb_powlib_fifo_unpack;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  always #5 clk = ~clk;

  powlib_fifo_unpack_if #(.W(8), .R(4)) bus0 ();
  powlib_fifo_unpack_if #(.W(8), .R(4)) bus1 ();

  powlib_fifo_unpack #(.W(8), .R(4), .EMSB(0), .EDBG(0), .ID("U0")) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  powlib_fifo_unpack #(.W(8), .R(4), .EMSB(1), .EDBG(0), .ID("U1")) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Monitors: pop/compare on a beat handshake, push the expected beats on an accept.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst && bus0.rdvld && bus0.rdrdy) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL beat0_unexpected: got %h last=%0b, wanted no beat", bus0.rddata, bus0.rdlast);
      end else begin
        e = q0.pop_front();
        if ({bus0.rddata, bus0.rdlast} !== e) begin
          errors++;
          $display("FAIL beat0: got %h last=%0b, wanted %h last=%0b", bus0.rddata, bus0.rdlast, e[8:1], e[0]);
        end
      end
    end
    if (bus0.wrvld && bus0.wrrdy) begin
      for (int i = 0; i <= int'(bus0.wrlen); i++)
        q0.push_back({bus0.wrdata[i*8 +: 8], i == int'(bus0.wrlen)});
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst && bus1.rdvld && bus1.rdrdy) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL beat1_unexpected: got %h last=%0b, wanted no beat", bus1.rddata, bus1.rdlast);
      end else begin
        e = q1.pop_front();
        if ({bus1.rddata, bus1.rdlast} !== e) begin
          errors++;
          $display("FAIL beat1: got %h last=%0b, wanted %h last=%0b", bus1.rddata, bus1.rdlast, e[8:1], e[0]);
        end
      end
    end
    if (bus1.wrvld && bus1.wrrdy) begin
      for (int i = 0; i <= int'(bus1.wrlen); i++)
        q1.push_back({bus1.wrdata[(3-i)*8 +: 8], i == int'(bus1.wrlen)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain0(input string name);
    int n = 0;
    while ((q0.size() != 0 || bus0.rdvld) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (q0.size() != 0 || bus0.rdvld !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending rdvld=%0b, wanted 0 pending rdvld=0", name, q0.size(), bus0.rdvld);
    end
  endtask

  task automatic accept0(input logic [31:0] d, input logic [1:0] len);
    bus0.wrdata = d;
    bus0.wrlen  = len;
    bus0.wrvld  = 1'b1;
    step();
    bus0.wrvld  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus0.wrvld  = 1'b1;
    bus0.wrdata = 32'hCAFEF00D;
    bus0.wrlen  = 2'd3;
    bus0.rdrdy  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks += 3;
      if (bus0.wrrdy !== 1'b0) begin errors++; $display("FAIL reset_wrrdy: got %0b, wanted 0", bus0.wrrdy); end
      if (bus0.rdvld !== 1'b0) begin errors++; $display("FAIL reset_rdvld: got %0b, wanted 0", bus0.rdvld); end
      if (bus0.rddata !== 8'h00) begin errors++; $display("FAIL reset_rddata: got %h, wanted 00", bus0.rddata); end
    end
    bus0.wrvld = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus0.wrrdy !== 1'b1) begin errors++; $display("FAIL release_wrrdy: got %0b, wanted 1", bus0.wrrdy); end
  endtask

  task automatic test_single();
    accept0(32'hDDCCBBAA, 2'd3);
    checks++;
    if (bus0.rdvld !== 1'b1 || bus0.rddata !== 8'hAA) begin
      errors++;
      $display("FAIL single_latency: got vld=%0b data=%h, wanted vld=1 data=aa", bus0.rdvld, bus0.rddata);
    end
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (bus0.rdvld !== 1'b0 || q0.size() != 0) begin
      errors++;
      $display("FAIL single_done: got vld=%0b pending=%0d, wanted vld=0 pending=0", bus0.rdvld, q0.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc = -1;
    accept0(32'h44332211, 2'd3);
    bus0.wrdata = 32'h88776655;
    bus0.wrlen  = 2'd1;
    bus0.wrvld  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (bus0.rdvld !== 1'b1) begin errors++; $display("FAIL b2b_bubble: cycle %0d got rdvld=%0b, wanted 1", c, bus0.rdvld); end
      if (bus0.wrvld && bus0.wrrdy) acc = c;
      step();
      if (acc >= 0) bus0.wrvld = 1'b0;
    end
    checks++;
    if (acc != 3) begin errors++; $display("FAIL b2b_accept_cycle: got %0d, wanted 3", acc); end
    checks++;
    if (bus0.rdvld !== 1'b0 || q0.size() != 0) begin
      errors++;
      $display("FAIL b2b_done: got vld=%0b pending=%0d, wanted vld=0 pending=0", bus0.rdvld, q0.size());
    end
  endtask

  task automatic test_backpressure();
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [8:0] prev = '0;
    logic       stalled = 1'b0;
    logic       exp_rdy;
    int         c = 0;
    accept0(32'h5A4B3C2D, 2'd3);
    while (q0.size() != 0 && c < 40) begin
      bus0.rdrdy = pat[c % 4];
      #1;
      exp_rdy = bus0.rdrdy && q0[0][0];
      checks++;
      if (bus0.wrrdy !== exp_rdy) begin errors++; $display("FAIL bp_wrrdy: cycle %0d got %0b, wanted %0b", c, bus0.wrrdy, exp_rdy); end
      if (stalled) begin
        checks++;
        if ({bus0.rddata, bus0.rdlast} !== prev) begin
          errors++;
          $display("FAIL bp_hold: cycle %0d got %h/%0b, wanted %h/%0b", c, bus0.rddata, bus0.rdlast, prev[8:1], prev[0]);
        end
      end
      prev    = {bus0.rddata, bus0.rdlast};
      stalled = !bus0.rdrdy;
      step();
      c++;
    end
    bus0.rdrdy = 1'b1;
    drain0("bp");
  endtask

  task automatic test_emsb();
    int n = 0;
    bus1.wrdata = 32'hDDCCBBAA;
    bus1.wrlen  = 2'd1;
    bus1.wrvld  = 1'b1;
    step();
    bus1.wrvld  = 1'b0;
    checks++;
    if (bus1.rdvld !== 1'b1 || bus1.rddata !== 8'hDD) begin
      errors++;
      $display("FAIL emsb_first: got vld=%0b data=%h, wanted vld=1 data=dd", bus1.rdvld, bus1.rddata);
    end
    while ((q1.size() != 0 || bus1.rdvld) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 2 || bus1.rdvld !== 1'b0) begin
      errors++;
      $display("FAIL emsb_len: got %0d cycles vld=%0b, wanted 2 cycles vld=0", n, bus1.rdvld);
    end
  endtask

  task automatic test_reset_mid();
    accept0(32'hDDCCBBAA, 2'd3);
    step();
    step();
    rst = 1'b0;
    step();
    q0.delete();
    checks++;
    if (bus0.rdvld !== 1'b0 || bus0.rdlast !== 1'b0) begin
      errors++;
      $display("FAIL midrst_vld: got vld=%0b last=%0b, wanted 0/0", bus0.rdvld, bus0.rdlast);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus0.rdvld !== 1'b0) begin errors++; $display("FAIL midrst_partial: got rdvld=%0b, wanted 0", bus0.rdvld); end
    end
    accept0(32'h0F0E0D0C, 2'd0);
    checks++;
    if (bus0.rddata !== 8'h0C || bus0.rdlast !== 1'b1) begin
      errors++;
      $display("FAIL midrst_new: got %h/%0b, wanted 0c/1", bus0.rddata, bus0.rdlast);
    end
    drain0("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus0.wrdata = '0; bus0.wrlen = '0; bus0.wrvld = 1'b0; bus0.rdrdy = 1'b1;
    bus1.wrdata = '0; bus1.wrlen = '0; bus1.wrvld = 1'b0; bus1.rdrdy = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_emsb();
    test_reset_mid();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d pending, wanted 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/powlib_fifo_unpack.md
Name: powlib_fifo_unpack

Overview:
Read-side width-down converter placed at the output of powlib_sfifo/powlib_afifo.
- Pops one wide entry (R narrow beats plus a beat count) through a valid/ready handshake.
- Replays the entry as a stream of W-bit beats on a downstream valid/ready port, flagging the final beat of each entry.
- Sustains one narrow beat per cycle with no bubble between consecutive entries.

Parameters:
W, 8, narrow beat width in bits.
R, 4, beats per wide entry; R>=2.
EMSB, 0, 0: beat 0 = wrdata[W-1:0]; 1: beat 0 = wrdata[R*W-1:(R-1)*W].
EDBG, 0, enable debug statements.
ID, "UNPACK", string identifier used in debug output.
Localparam WL = powlib_clogb2(R).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset.
wrdata  in  R*W  wide entry from the FIFO read side.
wrlen  in  WL  number of valid beats minus 1 (0 means 1 beat).
wrvld  in  1  wide entry valid.
wrrdy  out  1  wide entry accepted when wrvld && wrrdy.
rddata  out  W  current narrow beat.
rdlast  out  1  current beat is the final beat of its entry.
rdvld  out  1  narrow beat valid.
rdrdy  in  1  downstream ready.

Behaviour:
- Reset is sampled on a clk edge with rst==0. Reset values: rdvld=0, beat index=0, holding data=0, held length=0. Therefore rddata=0 and rdlast=0.
- While rst==0: wrrdy=0 (combinational gating) and no entry is accepted. Reset asserted mid-entry discards the remaining beats; no partial output follows reset release.
- States:
  - EMPTY: rdvld=0.
  - BUSY: rdvld=1, holding register loaded.
- Handshakes: wrinc = wrvld && wrrdy; rdinc = rdvld && rdrdy.
- wrrdy = rst && (EMPTY || (rdinc && rdlast)).
  - Combinational path from rdrdy to wrrdy is intentional; it provides zero-bubble back-to-back entries.
- EMPTY -> BUSY on wrinc.
  - Latch wrdata and the clamped length: lenq = min(wrlen, R-1). Clamping only matters when R is not a power of 2.
  - Set index=0. The first beat is visible the next cycle (1-cycle latency from accept to rdvld).
- BUSY, rdinc && !rdlast: index += 1.
- BUSY, rdinc && rdlast && wrinc: reload holding register and lenq, index=0, stay BUSY.
- BUSY, rdinc && rdlast && !wrinc: go to EMPTY, index=0.
- BUSY, !rdinc: all state holds.
  - rddata and rdlast are stable while rdvld && !rdrdy (AXI-style stability).
- rdlast = BUSY && (index == lenq).
- rddata = beat[index]: slice index*W when EMSB=0, slice (R-1-index)*W when EMSB=1.
- The index never exceeds lenq, so there is no wrap beyond R-1.
- Throughput: a full entry takes exactly (lenq+1) cycles when rdrdy is held at 1.
- wrdata and wrlen are ignored when wrvld==0.
- EDBG!=0:
  - An initial check displays ID and calls $finish if R<2.
  - Each wrinc displays ID, wrdata and wrlen.

Decomposition:
- Shared package powlib_std.vh: powlib_clogb2 only. No new typedefs.
- Index counter: one powlib_cntr instance (W=WL, ELD=0), with adv = rdinc && !rdlast and clr = rdinc && rdlast.
- Holding data and lenq: powlib_flipflop instances with EVLD=1 and vld=wrinc.
- State bit: powlib_flipflop.
- Beat selection mux: sub-module powlib_fifo_unpack_sel (combinational slice select, parameterized by W, R and EMSB).

Test Plan:
1. Reset: hold rst=0 for 3 cycles with wrvld=1 -> wrrdy=0, rdvld=0, rddata=0 throughout; after release, wrrdy=1 in the same cycle.
2. Single full entry: W=8, R=4, EMSB=0, wrdata=32'hDDCCBBAA, wrlen=3, rdrdy=1 -> beats AA, BB, CC, DD on consecutive cycles starting 1 cycle after accept; rdlast only on DD; then rdvld=0.
3. Back-to-back entries: 32'h44332211 (len 3) then 32'h88776655 (len 1), wrvld held -> the second entry is accepted on the DD-equivalent last-beat cycle. Output 11, 22, 33, 44, 55, 66 with no bubble; rdlast on 44 and 66.
4. Backpressure: rdrdy toggles 1,0,0,1 during an entry -> rddata and rdlast hold during the stalls; no beat is lost or duplicated; wrrdy stays 0 until the last beat handshakes.
5. EMSB=1 with a partial entry: wrdata=32'hDDCCBBAA, wrlen=1 -> beats DD, CC; rdlast on CC.
6. Reset mid-entry: assert rst=0 after beat BB of test 2 -> rdvld=0 the next cycle; after release, a new entry 32'h0F0E0D0C (len 0) outputs only 0C with rdlast=1.
